// File: rtl/float_add_arbiter.sv
// Two-requester round-robin sequencer around one shared 12-bit float adder.
// Float format: [11] sign (always 0), [10:7] exponent, [6:0] mantissa with
// an implicit leading 1. The adder only handles normal operands with
// exp(x) >= exp(y); zero, flush and overflow cases are handled here.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | arbitrate; the granted requester sees ready for one cycle
// ORDER | clear sign bits, put the larger exponent on X, detect zeros
// EXEC  | select adder output or a special-case value into the result
// RESP  | present the result; hold it until the consumer takes it

// Truncating adder; the caller guarantees exp(x) >= exp(y).
module float_add12 (
  input  logic [10:0] x,
  input  logic [10:0] y,
  output logic [11:0] z
);
  logic [3:0] exp_diff;
  logic [7:0] sig_x;
  logic [7:0] sig_y;
  logic [8:0] sum;

  // Align the smaller operand, add, and renormalise on carry-out.
  always_comb begin
    exp_diff = x[10:7] - y[10:7];
    sig_x    = {1'b1, x[6:0]};
    sig_y    = {1'b1, y[6:0]} >> exp_diff;
    sum      = {1'b0, sig_x} + {1'b0, sig_y};
    if (sum[8]) begin
      z = {1'b0, x[10:7] + 4'd1, sum[7:1]};
    end else begin
      z = {1'b0, x[10:7], sum[6:0]};
    end
  end
endmodule

module float_add_arbiter #(
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [11:0] req0_a,
  input  logic [11:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [11:0] req1_a,
  input  logic [11:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [11:0] rsp_z,
  output logic        rsp_ovf,
  output logic        rsp_flush,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ORDER, EXEC, RESP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic        gnt;
  logic        last_gnt;
  logic        id_r;
  logic [10:0] a_r;
  logic [10:0] b_r;
  logic [10:0] x_r;
  logic [10:0] y_r;
  logic        zx_r;
  logic        zy_r;
  logic [11:0] z_r;
  logic        ovf_r;
  logic        flush_r;
  logic [11:0] z_add;

  float_add12 u_add (
    .x (x_r),
    .y (y_r),
    .z (z_add)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, round-robin grant and the one-cycle ready pulse.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    gnt        = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (!reset) begin
          if (req0_valid && req1_valid) begin
            accept = 1'b1;
            gnt    = ~last_gnt;
          end else if (req0_valid) begin
            accept = 1'b1;
            gnt    = 1'b0;
          end else if (req1_valid) begin
            accept = 1'b1;
            gnt    = 1'b1;
          end
        end
        if (accept) begin
          state_nxt  = ORDER;
          req0_ready = ~gnt;
          req1_ready = gnt;
        end
      end
      ORDER:   state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture, order, result select and the last-grant pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_r     <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      x_r      <= '0;
      y_r      <= '0;
      zx_r     <= 1'b0;
      zy_r     <= 1'b0;
      z_r      <= '0;
      ovf_r    <= 1'b0;
      flush_r  <= 1'b0;
      last_gnt <= ~PRIO_INIT;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            id_r <= gnt;
            a_r  <= gnt ? req1_a[10:0] : req0_a[10:0];
            b_r  <= gnt ? req1_b[10:0] : req0_b[10:0];
          end
        end
        ORDER: begin
          // Sign bits were dropped at capture; equal exponents keep A on X.
          if (a_r[10:7] >= b_r[10:7]) begin
            x_r <= a_r;
            y_r <= b_r;
          end else begin
            x_r <= b_r;
            y_r <= a_r;
          end
          zx_r <= (a_r[10:7] >= b_r[10:7]) ? (a_r == '0) : (b_r == '0);
          zy_r <= (a_r[10:7] >= b_r[10:7]) ? (b_r == '0) : (a_r == '0);
        end
        EXEC: begin
          ovf_r   <= 1'b0;
          flush_r <= 1'b0;
          if (zx_r && zy_r) begin
            z_r <= 12'h000;
          end else if (zx_r || zy_r) begin
            z_r <= {1'b0, (zx_r ? y_r : x_r)};
          end else if (x_r[10:7] == 4'hF && z_add[10:7] == 4'h0) begin
            z_r   <= 12'h7FF;
            ovf_r <= 1'b1;
          end else begin
            z_r     <= z_add;
            flush_r <= ((x_r[10:7] - y_r[10:7]) >= 4'd8);
          end
        end
        RESP: begin
          if (rsp_ready) last_gnt <= id_r;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_id    = id_r;
  assign rsp_z     = z_r;
  assign rsp_ovf   = ovf_r;
  assign rsp_flush = flush_r;
endmodule

// File: tb/tb_float_add_arbiter.sv
module tb_float_add_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [11:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_ovf, rsp_flush, busy;
  logic [11:0] rsp_z;

  typedef struct packed {
    logic        id;
    logic [11:0] z;
    logic        ovf;
    logic        flush;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  float_add_arbiter #(.PRIO_INIT(1'b0)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .rsp_ovf(rsp_ovf), .rsp_flush(rsp_flush), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every response handshake pops and compares one entry.
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL rsp_unexpected: observed z=%h id=%0d expected no response", rsp_z, rsp_id);
      end
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("rsp_z", rsp_z, mon_e.z);
        chk("rsp_id", {11'b0, rsp_id}, {11'b0, mon_e.id});
        chk("rsp_ovf", {11'b0, rsp_ovf}, {11'b0, mon_e.ovf});
        chk("rsp_flush", {11'b0, rsp_flush}, {11'b0, mon_e.flush});
      end
    end
  end

  task automatic send(input logic id, input logic [11:0] a, input logic [11:0] b,
                      output int acc_cyc);
    int  n;
    bool_blk: begin
      @(posedge clk); #1;
      if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
      else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
      n = 0;
      forever begin
        @(negedge clk);
        if (id ? req1_ready : req0_ready) break;
        n++;
        if (n > 50) begin
          checks++; errors++;
          $error("FAIL send_timeout: observed no ready expected ready within 50 cycles");
          break;
        end
      end
      acc_cyc = cyc;
      @(posedge clk); #1;
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(output int c);
    int n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    assert (rsp_valid === 1'b1) else begin
      errors++;
      $error("FAIL rsp_timeout: observed rsp_valid=%b expected 1", rsp_valid);
    end
    c = cyc;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 60) begin @(negedge clk); n++; end
    checks++;
    assert (n < 60) else begin
      errors++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", sb.size());
    end
  endtask

  task automatic go(input logic id, input logic [11:0] a, input logic [11:0] b,
                    input logic [11:0] z, input logic ovf, input logic flush);
    int t;
    sb.push_back('{id: id, z: z, ovf: ovf, flush: flush});
    send(id, a, b, t);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t_acc, t_rsp, k;
    logic g [4];
    int   gc [4];
    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {11'b0, busy}, 12'h0);
    chk("reset_rsp_valid", {11'b0, rsp_valid}, 12'h0);
    chk("reset_rsp_z", rsp_z, 12'h000);
    chk("reset_rsp_flags", {9'b0, rsp_id, rsp_ovf, rsp_flush}, 12'h0);
    chk("reset_ready", {10'b0, req0_ready, req1_ready}, 12'h0);
    @(posedge clk); #1;
    reset = 1'b0; rsp_ready = 1'b1;

    // Equal exponents with latency check.
    sb.push_back('{id: 1'b0, z: 12'h300, ovf: 1'b0, flush: 1'b0});
    send(1'b0, 12'h280, 12'h280, t_acc);
    wait_rsp(t_rsp);
    chk("latency", 12'(t_rsp - t_acc), 12'd3);
    wait_done();

    go(1'b1, 12'h180, 12'h280, 12'h2A0, 1'b0, 1'b0);
    go(1'b0, 12'h100, 12'h600, 12'h600, 1'b0, 1'b1);
    go(1'b1, 12'h780, 12'h780, 12'h7FF, 1'b1, 1'b0);
    go(1'b0, 12'h000, 12'h2A0, 12'h2A0, 1'b0, 1'b0);
    go(1'b1, 12'h2A0, 12'h000, 12'h2A0, 1'b0, 1'b0);
    go(1'b0, 12'h000, 12'h000, 12'h000, 1'b0, 1'b0);
    go(1'b1, 12'hA80, 12'h280, 12'h300, 1'b0, 1'b0);
    go(1'b0, 12'h100, 12'h480, 12'h481, 1'b0, 1'b0);
    go(1'b0, 12'h100, 12'h500, 12'h500, 1'b0, 1'b1);

    // Arbitration straight after reset with both requesters valid.
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    req0_a = 12'h280; req0_b = 12'h280; req0_valid = 1'b1;
    req1_a = 12'h180; req1_b = 12'h280; req1_valid = 1'b1;
    k = 0;
    for (int n = 0; n < 40 && k < 4; n++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        chk("one_ready", {10'b0, req0_ready, req1_ready}, req1_ready ? 12'h1 : 12'h2);
        g[k]  = req1_ready;
        gc[k] = cyc;
        sb.push_back(req1_ready ? '{id: 1'b1, z: 12'h2A0, ovf: 1'b0, flush: 1'b0}
                                : '{id: 1'b0, z: 12'h300, ovf: 1'b0, flush: 1'b0});
        k++;
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("grant_count", 12'(k), 12'd4);
    for (int i = 0; i < k; i++) chk("grant_order", {11'b0, g[i]}, {11'b0, i[0]});
    for (int i = 1; i < k; i++) chk("grant_gap", 12'(gc[i] - gc[i-1]), 12'd4);
    wait_done();

    // Backpressure: result held, no ready to anyone.
    rsp_ready = 1'b0;
    sb.push_back('{id: 1'b0, z: 12'h300, ovf: 1'b0, flush: 1'b0});
    send(1'b0, 12'h280, 12'h280, t_acc);
    wait_rsp(t_rsp);
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_a = 12'h180; req1_b = 12'h280;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {11'b0, rsp_valid}, 12'h1);
      chk("bp_rsp_z", rsp_z, 12'h300);
      chk("bp_ready", {10'b0, req0_ready, req1_ready}, 12'h0);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0; rsp_ready = 1'b1;
    wait_done();

    // Reset during EXEC drops the in-flight pair.
    send(1'b1, 12'h280, 12'h280, t_acc);
    @(negedge clk);
    chk("order_busy", {11'b0, busy}, 12'h1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("exec_busy", {11'b0, busy}, 12'h1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", {11'b0, busy}, 12'h0);
    chk("post_reset_rsp_valid", {11'b0, rsp_valid}, 12'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("dropped_no_rsp", {11'b0, rsp_valid}, 12'h0);
    end
    chk("sb_empty", 12'(sb.size()), 12'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/float_add_arbiter.md
Name: float_add_arbiter

Overview:
- Sequencer and two-port arbiter around one shared instance of the 12-bit float adder (format: bit 11 sign, always 0; [10:7] exponent; [6:0] mantissa with implicit leading 1).
- Accepts operand pairs from two requesters using round-robin arbitration.
- Orders each pair so the larger exponent drives the adder's X input, and handles the zero, flush and overflow cases the adder does not cover.
- Returns one registered result per request on a single response channel tagged with the requester id.

Parameters:
PRIO_INIT, 0, requester granted first when both are valid after reset (0 or 1).

Ports:
clk  input  1  clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
req0_valid  input  1  requester 0 has an operand pair.
req0_ready  output  1  requester 0 pair accepted this cycle.
req0_a  input  12  requester 0 operand A.
req0_b  input  12  requester 0 operand B.
req1_valid  input  1  requester 1 has an operand pair.
req1_ready  output  1  requester 1 pair accepted this cycle.
req1_a  input  12  requester 1 operand A.
req1_b  input  12  requester 1 operand B.
rsp_valid  output  1  result valid.
rsp_ready  input  1  consumer takes the result.
rsp_id  output  1  requester that owns the result.
rsp_z  output  12  sum.
rsp_ovf  output  1  exponent overflow; result saturated.
rsp_flush  output  1  exponent difference ≥ 8; smaller operand dropped.
busy  output  1  FSM not in IDLE.

Behaviour:
- Reset: FSM=IDLE; all outputs 0; last-grant pointer set so PRIO_INIT wins the next tie. Reset mid-operation drops the in-flight pair with no response.
- States: IDLE → ORDER → EXEC → RESP → IDLE.
- IDLE arbitration:
  - Exactly one reqN_valid: that requester is granted.
  - Both valid: the requester not served last is granted.
  - Granted reqN_ready=1 for exactly one cycle, combinationally, in IDLE only. Operands and id are captured. Next state ORDER.
  - No valid: stay in IDLE.
- Request protocol: valid is held with stable data until ready. Ready is never asserted outside IDLE.
- ORDER:
  - Bit 11 of both operands is forced to 0.
  - If exp(A) ≥ exp(B): X=A, Y=B; otherwise swap. Equal exponents: no swap.
  - Zero detect: an operand equal to 12'h000 is zero.
  - X and Y are registered onto the adder inputs. Next state EXEC.
- EXEC: adder output sampled into the result register. Selection priority:
  1. Both operands zero: z=12'h000.
  2. Exactly one zero: z = the other operand (bypass).
  3. exp(X)=4'hF and adder exponent = 4'h0 (carry wrap): z=12'h7FF, ovf=1.
  4. Otherwise: z = adder output; flush=1 iff exp(X)−exp(Y) ≥ 8.
  - flush and ovf are 0 in the zero cases. Next state RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_z and flags are held stable.
  - On rsp_valid && rsp_ready: last-grant pointer := rsp_id; rsp_valid→0 next cycle; state→IDLE.
  - Backpressure holds RESP indefinitely.
- Latency: acceptance at cycle t gives rsp_valid at t+3. Throughput is one op per 4 cycles minimum (IDLE re-entry costs one cycle).
- busy=1 in ORDER, EXEC and RESP.
- No pipelining: a second request is never accepted while one is outstanding.

Test Plan:
- Equal exponents: req0 a=12'h280, b=12'h280 → rsp_z=12'h300, id=0, ovf=0, flush=0; rsp_valid 3 cycles after req0_ready.
- Swap: req1 a=12'h180, b=12'h280 → internal X=12'h280; rsp_z=12'h2A0, id=1, flags 0.
- Flush: a=12'h100, b=12'h600 → rsp_z=12'h600, flush=1.
- Overflow and zero: a=b=12'h780 → rsp_z=12'h7FF, ovf=1. a=12'h000, b=12'h2A0 → rsp_z=12'h2A0, flags 0.
- Arbitration, PRIO_INIT=0, both valid after reset with rsp_ready=1:
  - req0 is served first, then req1 ready asserts in the cycle after the req0 handshake completes.
  - With both still valid, the grants alternate 0,1,0,1.
- Backpressure and reset: rsp_ready=0 for 5 cycles → rsp_valid and rsp_z stable, no ready to either requester. Reset asserted during EXEC → the next cycle has busy=0, rsp_valid=0, and the pending pair is never returned.
